// File: rtl/mb_header_enc_p_if.sv
// Macroblock header encoder bus: MB parameters in, one codeword per handshake out.
interface mb_header_enc_p_if #(
    parameter int MVD_W  = 12,
    parameter int CODE_W = 32,
    parameter int LEN_W  = 6
);
    logic                    start;
    logic                    slice_p;
    logic                    first_mb;
    logic                    last_mb;
    logic [1:0]              mb_type;
    logic [5:0]              cbp;
    logic [1:0]              chroma_mode;
    logic [1:0]              i16_mode;
    logic [63:0]             i4_bm;
    logic [63:0]             i4_pm;
    logic signed [MVD_W-1:0] mvd_x;
    logic signed [MVD_W-1:0] mvd_y;
    logic [5:0]              qp;
    logic [5:0]              slice_qp;
    logic [CODE_W-1:0]       code;
    logic [LEN_W-1:0]        code_len;
    logic                    code_valid;
    logic                    code_ready;
    logic                    busy;
    logic                    done;

    modport master (
        output start, slice_p, first_mb, last_mb, mb_type, cbp,
        output chroma_mode, i16_mode, i4_bm, i4_pm, mvd_x, mvd_y,
        output qp, slice_qp, code_ready,
        input  code, code_len, code_valid, busy, done
    );

    modport slave (
        input  start, slice_p, first_mb, last_mb, mb_type, cbp,
        input  chroma_mode, i16_mode, i4_bm, i4_pm, mvd_x, mvd_y,
        input  qp, slice_qp, code_ready,
        output code, code_len, code_valid, busy, done
    );
endinterface

// File: rtl/mb_header_enc_p.sv
// H.264 macroblock header syntax encoder for I/P slices.
// Emits one Exp-Golomb (or fixed) codeword per element over a valid/ready bus.
module mb_header_enc_p #(
    parameter int MVD_W  = 12,
    parameter int CODE_W = 32,
    parameter int LEN_W  = 6
) (
    input logic              clk,
    input logic              rst_n,
    mb_header_enc_p_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, SKIPRUN, MBTYPE, PRED, CHROMA,
        MVDX, MVDY, CBP, DQP, FIN
    } state_t;

    localparam logic [1:0] T_I4 = 2'd0, T_I16 = 2'd1, T_P16 = 2'd2, T_SKIP = 2'd3;
    localparam int EW = CODE_W + LEN_W;

    // coded_block_pattern -> codeNum, indexed by cbp
    localparam logic [5:0] INTRA_CN [48] = '{
        3, 29, 30, 17, 31, 18, 37, 8, 32, 38, 19, 9, 20, 10, 11, 2,
        16, 33, 34, 21, 35, 22, 39, 4, 36, 40, 23, 5, 24, 6, 7, 1,
        41, 42, 43, 25, 44, 26, 46, 12, 45, 47, 27, 13, 28, 14, 15, 0};
    localparam logic [5:0] INTER_CN [48] = '{
        0, 2, 3, 7, 4, 8, 17, 13, 5, 18, 9, 14, 10, 15, 16, 11,
        1, 32, 33, 36, 34, 37, 44, 40, 35, 45, 38, 41, 39, 42, 43, 19,
        6, 24, 25, 20, 26, 21, 46, 28, 27, 47, 22, 29, 23, 30, 31, 12};

    state_t             r_state, w_next;
    logic               r_slice_p, r_last;
    logic [1:0]         r_type, r_cm, r_i16;
    logic [5:0]         r_cbp, r_qp, r_prev_qp;
    logic [63:0]        r_bm, r_pm;
    logic [MVD_W-1:0]   r_mvx, r_mvy;
    logic [15:0]        r_skip_run;
    logic [3:0]         r_blk;
    logic [1:0]         w_in_type;
    logic [9:0]         w_ap;
    logic               w_acc;
    logic [7:0]         w_t;
    logic [5:0]         w_cn;
    logic [3:0]         w_bm, w_pm, w_rem;
    logic signed [7:0]  w_delta;
    logic [EW-1:0]      w_elem;

    function automatic logic [1:0] eff_type(input logic sp, input logic [1:0] t);
        return (!sp && t[1]) ? T_I16 : t;
    endfunction

    function automatic logic [9:0] appl(input logic sp, input logic last,
                                        input logic [1:0] t, input logic [5:0] cbp);
        logic [9:0] a;
        a          = '0;
        a[SKIPRUN] = sp && (t != T_SKIP || last);
        a[MBTYPE]  = t != T_SKIP;
        a[PRED]    = t == T_I4;
        a[CHROMA]  = t == T_I4 || t == T_I16;
        a[MVDX]    = t == T_P16;
        a[MVDY]    = t == T_P16;
        a[CBP]     = t == T_I4 || t == T_P16;
        a[DQP]     = t == T_I16 || (t != T_SKIP && cbp != 6'd0);
        a[FIN]     = 1'b1;
        return a;
    endfunction

    // first applicable state after s; FIN always applies
    function automatic state_t nxt(input state_t s, input logic [9:0] ap);
        state_t n;
        n = FIN;
        for (int i = 9; i >= 1; i--)
            if (4'(i) > s && ap[i]) n = state_t'(4'(i));
        return n;
    endfunction

    function automatic logic [EW-1:0] ue(input logic [31:0] k);
        logic [32:0]      c;
        logic [LEN_W-1:0] n;
        c = {1'b0, k} + 33'd1;
        n = '0;
        for (int i = 0; i < 33; i++)
            if (c[i]) n = LEN_W'(2 * i + 1);
        return {CODE_W'(c), n};
    endfunction

    function automatic logic [EW-1:0] se(input logic signed [31:0] v);
        logic [31:0] k;
        k = (v > 0) ? 32'(2 * v - 1) : 32'(-2 * v);
        return ue(k);
    endfunction

    function automatic logic signed [31:0] sx(input logic [MVD_W-1:0] v);
        return {{(32-MVD_W){v[MVD_W-1]}}, v};
    endfunction

    assign w_in_type = eff_type(bus.slice_p, bus.mb_type);
    assign w_ap = (r_state == IDLE)
        ? appl(bus.slice_p, bus.last_mb, w_in_type, bus.cbp)
        : appl(r_slice_p, r_last, r_type, r_cbp);
    assign w_acc = bus.code_valid && bus.code_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == IDLE) begin
            if (bus.start) w_next = nxt(IDLE, w_ap);
        end else if (r_state == FIN) begin
            w_next = IDLE;
        end else if (w_acc && !(r_state == PRED && r_blk != 4'd15)) begin
            w_next = nxt(r_state, w_ap);
        end
    end

    always_comb begin
        w_t = 8'd0;
        if (r_type == T_I16)
            w_t = 8'd1 + {6'd0, r_i16} + {4'd0, r_cbp[5:4], 2'b00}
                + ((r_cbp[3:0] != 4'd0) ? 8'd12 : 8'd0);
        if (r_slice_p && (r_type == T_I4 || r_type == T_I16))
            w_t = w_t + 8'd5;
        w_cn = 6'd0;
        if (r_cbp < 6'd48)
            w_cn = (r_type == T_I4) ? INTRA_CN[r_cbp] : INTER_CN[r_cbp];
        w_bm  = r_bm[63:60];
        w_pm  = r_pm[63:60];
        w_rem = (w_bm > w_pm) ? w_bm - 4'd1 : w_bm;
        // qp difference wrapped into [-26,25]
        w_delta = $signed({2'b00, r_qp}) - $signed({2'b00, r_prev_qp});
        if (w_delta > 8'sd25)       w_delta = w_delta - 8'sd52;
        else if (w_delta < -8'sd26) w_delta = w_delta + 8'sd52;
    end

    always_comb begin
        w_elem = '0;
        unique case (r_state)
            SKIPRUN: w_elem = ue(32'(r_skip_run));
            MBTYPE:  w_elem = ue(32'(w_t));
            PRED:    w_elem = (w_bm == w_pm) ? {CODE_W'(1), LEN_W'(1)}
                                             : {CODE_W'({1'b0, w_rem[2:0]}), LEN_W'(4)};
            CHROMA:  w_elem = ue(32'(r_cm));
            MVDX:    w_elem = se(sx(r_mvx));
            MVDY:    w_elem = se(sx(r_mvy));
            CBP:     w_elem = ue(32'(w_cn));
            DQP:     w_elem = se({{24{w_delta[7]}}, w_delta});
            default: w_elem = '0;
        endcase
    end

    assign bus.code       = w_elem[EW-1:LEN_W];
    assign bus.code_len   = w_elem[LEN_W-1:0];
    assign bus.code_valid = r_state != IDLE && r_state != FIN;
    assign bus.busy       = r_state != IDLE;
    assign bus.done       = r_state == FIN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slice_p  <= 1'b0;
            r_last     <= 1'b0;
            r_type     <= 2'd0;
            r_cm       <= 2'd0;
            r_i16      <= 2'd0;
            r_cbp      <= 6'd0;
            r_qp       <= 6'd0;
            r_prev_qp  <= 6'd0;
            r_bm       <= '0;
            r_pm       <= '0;
            r_mvx      <= '0;
            r_mvy      <= '0;
            r_skip_run <= 16'd0;
            r_blk      <= 4'd0;
        end else if (r_state == IDLE && bus.start) begin
            r_slice_p <= bus.slice_p;
            r_last    <= bus.last_mb;
            r_type    <= w_in_type;
            r_cm      <= bus.chroma_mode;
            r_i16     <= bus.i16_mode;
            r_cbp     <= bus.cbp;
            r_qp      <= bus.qp;
            r_bm      <= bus.i4_bm;
            r_pm      <= bus.i4_pm;
            r_mvx     <= bus.mvd_x;
            r_mvy     <= bus.mvd_y;
            r_blk     <= 4'd0;
            if (bus.first_mb) begin
                r_prev_qp  <= bus.slice_qp;
                r_skip_run <= (w_in_type == T_SKIP) ? 16'd1 : 16'd0;
            end else if (w_in_type == T_SKIP && r_skip_run != 16'hFFFF) begin
                r_skip_run <= r_skip_run + 16'd1;
            end
        end else if (w_acc) begin
            if (r_state == SKIPRUN) r_skip_run <= 16'd0;
            if (r_state == DQP)     r_prev_qp  <= r_qp;
            if (r_state == PRED) begin
                r_bm  <= r_bm << 4;
                r_pm  <= r_pm << 4;
                r_blk <= r_blk + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_mb_header_enc_p.sv
// Randomized bench for mb_header_enc_p against a syntax-level reference model.
module tb_mb_header_enc_p;
    localparam int MVD_W = 12, CODE_W = 32, LEN_W = 6;

    typedef struct {
        bit sp, first, last;
        int t, cbp, cm, i16;
        bit [63:0] bm, pm;
        int mvx, mvy, qp, sqp;
    } mb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_err = 0;
    int m_prev = 0;
    int m_skip = 0;
    longint q_code[$];
    int q_len[$];

    // Table 9-4 (ChromaArrayType 1/2), indexed by codeNum
    int INTRA_T[48] = '{47, 31, 15, 0, 23, 27, 29, 30, 7, 11, 13, 14, 39, 43, 45, 46,
                        16, 3, 5, 10, 12, 19, 21, 26, 28, 35, 37, 42, 44, 1, 2, 4,
                        8, 17, 18, 20, 24, 6, 9, 22, 25, 32, 33, 34, 36, 40, 38, 41};
    int INTER_T[48] = '{0, 16, 1, 2, 4, 8, 32, 3, 5, 10, 12, 15, 47, 7, 11, 13,
                        14, 6, 9, 31, 35, 37, 42, 44, 33, 34, 36, 40, 39, 43, 45, 46,
                        17, 18, 20, 24, 19, 21, 26, 28, 23, 27, 29, 30, 22, 25, 38, 41};

    mb_header_enc_p_if #(.MVD_W(MVD_W), .CODE_W(CODE_W), .LEN_W(LEN_W)) bus ();

    mb_header_enc_p #(.MVD_W(MVD_W), .CODE_W(CODE_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", tag, got, exp);
        end
    endtask

    function automatic void ex(input longint c, input int l);
        q_code.push_back(c);
        q_len.push_back(l);
    endfunction

    function automatic void push_ue(input int k);
        int x, n;
        x = k + 1;
        n = 0;
        while (x > 1) begin
            x = x >> 1;
            n++;
        end
        ex(k + 1, 2 * n + 1);
    endfunction

    function automatic void push_se(input int v);
        push_ue(v > 0 ? 2 * v - 1 : -2 * v);
    endfunction

    function automatic void build_exp(input mb_t m);
        int t, cn, d, b, pm;
        t = (!m.sp && m.t >= 2) ? 1 : m.t;
        if (m.first) begin
            m_prev = m.sqp;
            m_skip = 0;
        end
        if (t == 3) begin
            if (m_skip < 65535) m_skip++;
            if (m.last) begin
                push_ue(m_skip);
                m_skip = 0;
            end
            return;
        end
        if (m.sp) begin
            push_ue(m_skip);
            m_skip = 0;
        end
        if (t == 0) push_ue(m.sp ? 5 : 0);
        if (t == 1) push_ue(1 + m.i16 + 4 * (m.cbp / 16) + ((m.cbp % 16) != 0 ? 12 : 0)
                            + (m.sp ? 5 : 0));
        if (t == 2) push_ue(0);
        if (t == 0)
            for (int i = 0; i < 16; i++) begin
                b  = int'((m.bm >> (60 - 4 * i)) & 64'hF);
                pm = int'((m.pm >> (60 - 4 * i)) & 64'hF);
                if (b == pm) ex(1, 1);
                else ex((b > pm ? b - 1 : b) % 8, 4);
            end
        if (t <= 1) push_ue(m.cm);
        if (t == 2) begin
            push_se(m.mvx);
            push_se(m.mvy);
        end
        if (t != 1) begin
            cn = 0;
            for (int c = 0; c < 48; c++)
                if ((t == 0 ? INTRA_T[c] : INTER_T[c]) == m.cbp) cn = c;
            push_ue(cn);
        end
        if (t == 1 || m.cbp != 0) begin
            d = m.qp - m_prev;
            if (d > 25) d -= 52;
            if (d < -26) d += 52;
            push_se(d);
            m_prev = m.qp;
        end
    endfunction

    function automatic mb_t mk(input bit sp, input bit first, input bit last, input int t);
        mb_t m;
        m.sp = sp; m.first = first; m.last = last; m.t = t;
        m.cbp = 0; m.cm = 0; m.i16 = 0; m.bm = '0; m.pm = '0;
        m.mvx = 0; m.mvy = 0; m.qp = 26; m.sqp = 26;
        return m;
    endfunction

    task automatic prep(input mb_t m);
        build_exp(m);
        q_code.delete();
        q_len.delete();
    endtask

    // stall_at < 0: random ready; else ready except 3 cycles after stall_at handshakes
    task automatic run_mb(input mb_t m, input int stall_at);
        int n_hs, n_st;
        bit exp_done, prev_stall, fin;
        logic [CODE_W-1:0] h_code;
        logic [LEN_W-1:0] h_len;
        @(negedge clk);
        bus.slice_p = m.sp; bus.first_mb = m.first; bus.last_mb = m.last;
        bus.mb_type = 2'(m.t); bus.cbp = 6'(m.cbp);
        bus.chroma_mode = 2'(m.cm); bus.i16_mode = 2'(m.i16);
        bus.i4_bm = m.bm; bus.i4_pm = m.pm;
        bus.mvd_x = MVD_W'(m.mvx); bus.mvd_y = MVD_W'(m.mvy);
        bus.qp = 6'(m.qp); bus.slice_qp = 6'(m.sqp);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("first_valid", bus.code_valid, q_code.size() != 0);
        chk("busy", bus.busy, 1);
        exp_done = q_code.size() == 0;
        n_hs = 0; n_st = 0; prev_stall = 0; fin = 0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (prev_stall) begin
                chk("hold_code", bus.code, h_code);
                chk("hold_len", bus.code_len, h_len);
            end
            chk("done", bus.done, exp_done);
            if (exp_done || bus.done) begin
                chk("busy_done", bus.busy, 1);
                fin = 1;
            end else begin
                if (stall_at >= 0 && n_hs == stall_at && n_st < 3) begin
                    bus.code_ready = 1'b0;
                    n_st++;
                end else begin
                    bus.code_ready = (stall_at >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
                chk("valid", bus.code_valid, q_code.size() != 0);
                if (bus.code_valid && bus.code_ready && q_code.size() != 0) begin
                    chk("code", bus.code, q_code.pop_front());
                    chk("len", bus.code_len, q_len.pop_front());
                    n_hs++;
                    if (q_code.size() == 0) exp_done = 1;
                end
                prev_stall = bus.code_valid && !bus.code_ready;
                h_code = bus.code;
                h_len = bus.code_len;
            end
        end
        if (!fin) chk("timeout", 0, 1);
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
    endtask

    initial begin
        mb_t m;
        bit cur_sp;
        bus.start = 0; bus.slice_p = 0; bus.first_mb = 0; bus.last_mb = 0;
        bus.mb_type = 0; bus.cbp = 0; bus.chroma_mode = 0; bus.i16_mode = 0;
        bus.i4_bm = 0; bus.i4_pm = 0; bus.mvd_x = 0; bus.mvd_y = 0;
        bus.qp = 0; bus.slice_qp = 0; bus.code_ready = 0;
        repeat (3) @(negedge clk);
        chk("rst_code", bus.code, 0);
        chk("rst_len", bus.code_len, 0);
        chk("rst_valid", bus.code_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;

        m = mk(0, 1, 0, 1); m.i16 = 2; m.cbp = 6'h10; m.qp = 28; m.sqp = 28;
        prep(m); ex(8, 7); ex(1, 1); ex(1, 1);
        run_mb(m, -1);

        m = mk(0, 1, 0, 0); m.bm = 64'h5000_0000_0000_0000; m.pm = 64'h3000_0000_0000_0000;
        prep(m); ex(1, 1); ex(4, 4);
        for (int i = 0; i < 15; i++) ex(1, 1);
        ex(1, 1); ex(4, 5);
        run_mb(m, -1);

        prep(m); ex(1, 1); ex(4, 4);
        for (int i = 0; i < 15; i++) ex(1, 1);
        ex(1, 1); ex(4, 5);
        run_mb(m, 3);

        m = mk(1, 1, 0, 3); prep(m); run_mb(m, -1);
        m = mk(1, 0, 0, 3); prep(m); run_mb(m, -1);
        prep(m); run_mb(m, -1);
        m = mk(1, 0, 0, 2); m.mvx = -3; m.mvy = 2;
        prep(m); ex(4, 5); ex(1, 1); ex(7, 5); ex(4, 5); ex(1, 1);
        run_mb(m, -1);

        m = mk(0, 1, 0, 1); m.sqp = 51; m.qp = 0;
        prep(m); ex(2, 3); ex(1, 1); ex(2, 3);
        run_mb(m, -1);
        m = mk(0, 0, 0, 1); m.qp = 0;
        prep(m); ex(2, 3); ex(1, 1); ex(1, 1);
        run_mb(m, -1);

        m = mk(1, 1, 0, 3); prep(m); run_mb(m, -1);
        m = mk(1, 0, 1, 3); prep(m); ex(3, 3); run_mb(m, -1);
        m = mk(1, 0, 0, 2);
        prep(m); ex(1, 1); ex(1, 1); ex(1, 1); ex(1, 1); ex(1, 1);
        run_mb(m, -1);

        // reset while encoding intra 4x4 modes
        @(negedge clk);
        bus.slice_p = 0; bus.first_mb = 1; bus.mb_type = 0; bus.cbp = 6'h0F;
        bus.i4_bm = 64'h1234_5678_1234_5678; bus.i4_pm = '0;
        bus.code_ready = 1; bus.start = 1;
        @(negedge clk);
        bus.start = 0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_code", bus.code, 0);
        chk("mid_rst_len", bus.code_len, 0);
        chk("mid_rst_valid", bus.code_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        m_prev = 0;
        m_skip = 0;
        m = mk(0, 0, 0, 1); m.qp = 10;
        prep(m); ex(2, 3); ex(1, 1); ex(20, 9);
        run_mb(m, -1);

        cur_sp = 0;
        for (int i = 0; i < 150; i++) begin
            if (i % 10 == 0) cur_sp = 1'($urandom_range(0, 1));
            m = mk(cur_sp, i % 10 == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3));
            m.cbp = 16 * $urandom_range(0, 2) + $urandom_range(0, 15);
            m.cm = $urandom_range(0, 3);
            m.i16 = $urandom_range(0, 3);
            for (int b = 0; b < 16; b++) begin
                m.bm = (m.bm << 4) | 64'($urandom_range(0, 8));
                m.pm = (m.pm << 4) | 64'($urandom_range(0, 8));
            end
            m.mvx = int'($urandom_range(0, 4095)) - 2048;
            m.mvy = int'($urandom_range(0, 4095)) - 2048;
            m.qp = $urandom_range(0, 51);
            m.sqp = $urandom_range(0, 51);
            build_exp(m);
            run_mb(m, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
